// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter and the mux_Nx1 stage it drives.
// Select-width helper keeps both blocks agreeing on sel width for any N.
package mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Index successor modulo n; n=1 always yields 0.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/select/handshake bundle between sources, the arbiter and the mux consumer.
// master drives requests and readiness; slave is the arbiter.
interface rr_mux_arbiter_if
  import mux_pkg::*;
#(
  parameter int N = 8
);

  localparam int SEL_WIDTH = sel_width(N);

  logic [N-1:0]         req;
  logic                 out_ready;
  logic [SEL_WIDTH-1:0] sel;
  logic                 out_valid;
  logic [N-1:0]         gnt;

  modport master (
    output req,
    output out_ready,
    input  sel,
    input  out_valid,
    input  gnt
  );

  modport slave (
    input  req,
    input  out_ready,
    output sel,
    output out_valid,
    output gnt
  );

endinterface

// File: rtl/rr_mux_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first set bit of vec searching ptr, ptr+1, ..., wrapping.
// The vector is doubled so the wrap needs no modulo, which keeps non-power-of-two N correct.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]            vec,
  input  logic [sel_width(N)-1:0] ptr,
  output logic [sel_width(N)-1:0] idx,
  output logic                    any
);

  localparam int SEL_WIDTH = sel_width(N);

  logic [2*N-1:0] dbl;

  assign dbl = {vec, vec};

  // Scan high to low so the lowest position inside the window [ptr, ptr+N) wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl[j] && (j >= int'(ptr)) && (j < int'(ptr) + N)) begin
        any = 1'b1;
        idx = (j >= N) ? SEL_WIDTH'(j - N) : SEL_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter producing the registered select and valid/ready handshake for an N-input mux.
// Grant is a combinational decode of the transfer; back-to-back arbitration avoids bubbles.
module rr_mux_arbiter
  import mux_pkg::*;
#(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_mux_arbiter_if.slave bus
);

  localparam int SEL_WIDTH = sel_width(N);

  arb_state_e           state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;

  logic                 out_valid;
  logic                 xfer;
  logic [SEL_WIDTH-1:0] sel_inc;
  logic [N-1:0]         gnt_vec;
  logic [N-1:0]         pick_vec;
  logic [SEL_WIDTH-1:0] pick_ptr;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_any;

  assign out_valid = (state_q == BUSY);
  assign xfer      = out_valid & bus.out_ready;
  assign sel_inc   = SEL_WIDTH'(wrap_inc(int'(sel_q), N));

  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < N; i++) begin
      gnt_vec[i] = rst_n & xfer & (sel_q == SEL_WIDTH'(i));
    end
  end

  // One encoder serves both cases: fresh pick from IDLE, or the masked re-pick on a transfer.
  always_comb begin
    pick_vec = bus.req;
    pick_ptr = ptr_q;
    if (state_q == BUSY) begin
      pick_vec = bus.req & ~gnt_vec;
      pick_ptr = sel_inc;
    end
  end

  rr_pick #(
    .N (N)
  ) u_pick (
    .vec (pick_vec),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.out_ready) begin
          ptr_d = sel_inc;
          if (pick_any) begin
            sel_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid;
  assign bus.gnt       = gnt_vec;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: N=8 and N=5 instances against a search-order reference model.
// Directed scenarios first, then randomized requests and readiness.
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_mux_arbiter_if #(.N(8)) bus8 ();
  rr_mux_arbiter_if #(.N(5)) bus5 ();

  rr_mux_arbiter #(.N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  rr_mux_arbiter #(.N(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 is the N=8 instance, index 1 the N=5 instance.
  int         m_valid [2];
  int         m_sel   [2];
  int         m_ptr   [2];
  int         m_n     [2] = '{8, 5};
  logic [7:0] cur_req [2];
  logic       cur_rdy [2];

  function automatic int firstInOrder(input logic [7:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [7:0] expGnt(input int d);
    if (m_valid[d] != 0 && cur_rdy[d]) return 8'(1 << m_sel[d]);
    return 8'h00;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0;
      m_sel[d]   = 0;
      m_ptr[d]   = 0;
    end
  endtask

  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      logic [7:0] r;
      int         w;
      r = cur_req[d] & ((8'h01 << m_n[d]) - 8'h01);
      if (m_valid[d] == 0) begin
        w = firstInOrder(r, m_ptr[d], m_n[d]);
        if (w >= 0) begin
          m_sel[d]   = w;
          m_valid[d] = 1;
        end
      end else if (cur_rdy[d]) begin
        m_ptr[d]    = (m_sel[d] + 1) % m_n[d];
        r[m_sel[d]] = 1'b0;
        w = firstInOrder(r, m_ptr[d], m_n[d]);
        if (w >= 0) m_sel[d] = w;
        else        m_valid[d] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] e8;
    logic [7:0] e5;
    e8 = expGnt(0);
    e5 = expGnt(1);
    checks++;
    assert (bus8.sel === 3'(m_sel[0])) else begin
      errors++;
      $error("[TB] FAIL %s sel8: got %0d expected %0d", tag, bus8.sel, m_sel[0]);
    end
    checks++;
    assert (bus8.out_valid === (m_valid[0] != 0)) else begin
      errors++;
      $error("[TB] FAIL %s out_valid8: got %b expected %0d", tag, bus8.out_valid, m_valid[0]);
    end
    checks++;
    assert (bus8.gnt === e8) else begin
      errors++;
      $error("[TB] FAIL %s gnt8: got %b expected %b", tag, bus8.gnt, e8);
    end
    checks++;
    assert (bus5.sel === 3'(m_sel[1])) else begin
      errors++;
      $error("[TB] FAIL %s sel5: got %0d expected %0d", tag, bus5.sel, m_sel[1]);
    end
    checks++;
    assert (bus5.out_valid === (m_valid[1] != 0)) else begin
      errors++;
      $error("[TB] FAIL %s out_valid5: got %b expected %0d", tag, bus5.out_valid, m_valid[1]);
    end
    checks++;
    assert (bus5.gnt === e5[4:0]) else begin
      errors++;
      $error("[TB] FAIL %s gnt5: got %b expected %b", tag, bus5.gnt, e5[4:0]);
    end
    checks++;
    assert (bus5.sel < 3'd5) else begin
      errors++;
      $error("[TB] FAIL %s sel5_range: got %0d expected below 5", tag, bus5.sel);
    end
  endtask

  task automatic driveInputs(input logic [7:0] r8, input logic rdy8,
                             input logic [4:0] r5, input logic rdy5);
    cur_req[0]     = r8;
    cur_rdy[0]     = rdy8;
    cur_req[1]     = {3'b000, r5};
    cur_rdy[1]     = rdy5;
    bus8.req       = r8;
    bus8.out_ready = rdy8;
    bus5.req       = r5;
    bus5.out_ready = rdy5;
  endtask

  // One cycle: inputs change just after a rising edge, outputs are checked at the falling edge.
  task automatic applyStimulus(input string tag, input logic [7:0] r8, input logic rdy8,
                               input logic [4:0] r5, input logic rdy5);
    driveInputs(r8, rdy8, r5, rdy5);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic resetPulse();
    rst_n = 1'b0;
    driveInputs(8'h00, 1'b0, 5'h00, 1'b0);
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  initial begin
    $display("[TB] start");
    resetPulse();

    // Single request: one-cycle latency, grant on transfer, back to IDLE.
    applyStimulus("single_req", 8'h04, 1'b1, 5'h00, 1'b0);
    applyStimulus("single_gnt", 8'h04, 1'b1, 5'h00, 1'b0);
    applyStimulus("single_idle", 8'h00, 1'b1, 5'h00, 1'b0);

    // All requesters held: sel walks 0..7 and wraps with no bubble.
    resetPulse();
    for (int i = 0; i < 11; i++) applyStimulus("all_req", 8'hFF, 1'b1, 5'h00, 1'b0);
    applyStimulus("flush", 8'h00, 1'b1, 5'h00, 1'b0);
    applyStimulus("flush", 8'h00, 1'b1, 5'h00, 1'b0);

    // Bring ptr to 7 via a grant on bit 6, then check the 7 -> 0 wrap.
    applyStimulus("ptr7_req", 8'h40, 1'b1, 5'h00, 1'b0);
    applyStimulus("ptr7_gnt", 8'h40, 1'b1, 5'h00, 1'b0);
    applyStimulus("wrap_req", 8'h81, 1'b1, 5'h00, 1'b0);
    applyStimulus("wrap_sel7", 8'h81, 1'b1, 5'h00, 1'b0);
    applyStimulus("wrap_sel0", 8'h01, 1'b1, 5'h00, 1'b0);
    applyStimulus("wrap_idle", 8'h00, 1'b1, 5'h00, 1'b0);

    // Stall at sel=3 while other request bits toggle.
    applyStimulus("stall_req", 8'h08, 1'b0, 5'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("stall", 8'h08 | (8'($urandom) & 8'hF7), 1'b0, 5'h00, 1'b0);
    end
    applyStimulus("stall_release", 8'h08, 1'b1, 5'h00, 1'b0);
    applyStimulus("flush", 8'h00, 1'b1, 5'h00, 1'b0);
    applyStimulus("flush", 8'h00, 1'b1, 5'h00, 1'b0);

    // Reset asserted mid-BUSY at sel=5, then the pending request is re-granted.
    applyStimulus("busy5", 8'h20, 1'b0, 5'h00, 1'b0);
    driveInputs(8'h20, 1'b1, 5'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    checkOutput("reset_hold");
    rst_n = 1'b1;
    @(posedge clk);
    modelStep();
    #1;
    applyStimulus("regrant", 8'h20, 1'b1, 5'h00, 1'b0);
    applyStimulus("regrant_idle", 8'h00, 1'b1, 5'h00, 1'b0);

    // N=5: reach ptr=4 via a grant on bit 3, then check the 4 -> 0 wrap.
    applyStimulus("n5_ptr4_req", 8'h00, 1'b1, 5'b01000, 1'b1);
    applyStimulus("n5_ptr4_gnt", 8'h00, 1'b1, 5'b01000, 1'b1);
    applyStimulus("n5_wrap_req", 8'h00, 1'b1, 5'b10001, 1'b1);
    applyStimulus("n5_sel4", 8'h00, 1'b1, 5'b10001, 1'b1);
    applyStimulus("n5_sel0", 8'h00, 1'b1, 5'b00001, 1'b1);
    applyStimulus("n5_idle", 8'h00, 1'b1, 5'b00000, 1'b1);

    // Randomized requests and readiness on both instances.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("random", 8'($urandom), ($urandom_range(0, 3) != 0),
                    5'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
